// File: rtl/data_mem_arbiter_if.sv
// Requester-side and RAM-side signals of the two-master data memory arbiter.
interface data_mem_arbiter_if #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
);
  logic                     req0, req1;
  logic                     we0, we1;
  logic                     lock0, lock1;
  logic [RAM_ADDR_BITS-1:0] addr0, addr1;
  logic [RAM_WIDTH-1:0]     wdata0, wdata1;
  logic                     gnt0, gnt1;
  logic                     rvalid0, rvalid1;
  logic [RAM_WIDTH-1:0]     rdata;
  logic                     mem_enable;
  logic                     mem_write_enable;
  logic [RAM_ADDR_BITS-1:0] mem_address;
  logic [RAM_WIDTH-1:0]     mem_in_data;
  logic [RAM_WIDTH-1:0]     mem_out_data;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_out_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_enable, mem_write_enable, mem_address, mem_in_data
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, mem_out_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           mem_enable, mem_write_enable, mem_address, mem_in_data
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port sync RAM between two requesters, with lock.
// Optional lock timeout: define MEM_ARB_LOCK_TIMEOUT_EN (bounded by LOCK_MAX).
module data_mem_arbiter #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9,
  parameter int LOCK_MAX      = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_OWN0 = 2'd1, ARB_OWN1 = 2'd2} arb_state_t;

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("LOCK_MAX must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       ptr, ptr_nxt;
  logic [1:0] req, we, lock, gnt_raw, gnt, acc, rvalid;
  logic       sel, force_rel;
  logic [1:0][RAM_ADDR_BITS-1:0] addr;
  logic [1:0][RAM_WIDTH-1:0]     wdata;
  logic [RAM_ADDR_BITS-1:0]      last_addr;
  logic [RAM_WIDTH-1:0]          last_wdata;

  assign req   = {bus.req1,   bus.req0};
  assign we    = {bus.we1,    bus.we0};
  assign lock  = {bus.lock1,  bus.lock0};
  assign addr  = {bus.addr1,  bus.addr0};
  assign wdata = {bus.wdata1, bus.wdata0};

  always_comb begin
    gnt_raw   = '0;
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ARB_IDLE: begin
        if (req[0] && (!req[1] || !ptr)) gnt_raw[0] = 1'b1;
        else if (req[1])                 gnt_raw[1] = 1'b1;
        if (gnt_raw[0]) begin
          ptr_nxt = 1'b1;
          if (lock[0]) state_nxt = ARB_OWN0;
        end
        if (gnt_raw[1]) begin
          ptr_nxt = 1'b0;
          if (lock[1]) state_nxt = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        gnt_raw[0] = req[0];
        if (!lock[0] || force_rel) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      ARB_OWN1: begin
        gnt_raw[1] = req[1];
        if (!lock[1] || force_rel) begin
          state_nxt = ARB_IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Grants are forced low while reset is asserted, independent of state.
  assign gnt = gnt_raw & {2{reset_n}};
  assign acc = req & gnt;
  assign sel = acc[1];

`ifdef MEM_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  logic [CNT_W-1:0] lock_cnt, cnt_inc;
  logic             own_idx, own_acc;

  // The grant that takes ownership counts as the first locked grant.
  assign own_idx   = (state == ARB_OWN1);
  assign own_acc   = acc[own_idx];
  assign cnt_inc   = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + CNT_W'(own_acc);
  assign force_rel = (state != ARB_IDLE) && (cnt_inc == CNT_MAX) && req[~own_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                        lock_cnt <= '0;
    else if (state_nxt == ARB_IDLE)                      lock_cnt <= '0;
    else if (state == ARB_IDLE)                          lock_cnt <= CNT_W'(1);
    else                                                 lock_cnt <= cnt_inc;
  end
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      ptr        <= 1'b0;
      rvalid     <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      rvalid <= acc & ~we;
      if (|acc) begin
        last_addr  <= addr[sel];
        last_wdata <= wdata[sel];
      end
    end
  end

  assign bus.gnt0             = gnt[0];
  assign bus.gnt1             = gnt[1];
  assign bus.rvalid0          = rvalid[0];
  assign bus.rvalid1          = rvalid[1];
  assign bus.rdata            = bus.mem_out_data;
  assign bus.mem_enable       = |acc;
  assign bus.mem_write_enable = (|acc) & we[sel];
  assign bus.mem_address      = (|acc) ? addr[sel]  : last_addr;
  assign bus.mem_in_data      = (|acc) ? wdata[sel] : last_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural single-port RAM.
module tb_data_mem_arbiter;
  localparam int W = 32;
  localparam int A = 9;

  logic clock = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [W-1:0] ram [0:(1<<A)-1];

  always #5 clock = ~clock;

  data_mem_arbiter_if #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

  data_mem_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(A), .LOCK_MAX(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always @(posedge clock) begin
    if (bus.mem_enable) begin
      if (bus.mem_write_enable) ram[bus.mem_address] <= bus.mem_in_data;
      else                      bus.mem_out_data     <= ram[bus.mem_address];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic w, input logic l, input logic [A-1:0] a, input logic [W-1:0] d);
    bus.req0 = r; bus.we0 = w; bus.lock0 = l; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drv1(input logic r, input logic w, input logic l, input logic [A-1:0] a, input logic [W-1:0] d);
    bus.req1 = r; bus.we1 = w; bus.lock1 = l; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic tk();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tk(); tk();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 9'h010, '0);
    drv1(1'b1, 1'b0, 1'b0, 9'h001, '0);
    tk(); tk();
    @(negedge clock);
    chk("rst_gnt0",   bus.gnt0, 0);
    chk("rst_gnt1",   bus.gnt1, 0);
    chk("rst_men",    bus.mem_enable, 0);
    chk("rst_mwe",    bus.mem_write_enable, 0);
    chk("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
    drv0(1'b0, 1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, 1'b0, '0, '0);
    tk();
    reset_n = 1'b1;

    // write then read back, requester 0 only
    tk(); drv0(1'b1, 1'b1, 1'b0, 9'h010, 32'hDEADBEEF);
    @(negedge clock);
    chk("wr_gnt0", bus.gnt0, 1);
    chk("wr_men",  bus.mem_enable, 1);
    chk("wr_mwe",  bus.mem_write_enable, 1);
    chk("wr_addr", bus.mem_address, 9'h010);
    chk("wr_data", bus.mem_in_data, 32'hDEADBEEF);
    tk(); drv0(1'b1, 1'b0, 1'b0, 9'h010, '0);
    @(negedge clock);
    chk("rd_gnt0",   bus.gnt0, 1);
    chk("rd_mwe",    bus.mem_write_enable, 0);
    chk("wr_norv",   bus.rvalid0, 0);
    tk(); drv0(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    chk("rd_rv0",    bus.rvalid0, 1);
    chk("rd_rv1",    bus.rvalid1, 0);
    chk("rd_data",   bus.rdata, 32'hDEADBEEF);
    chk("idle_men",  bus.mem_enable, 0);
    chk("idle_addr", bus.mem_address, 9'h010);
    tk();
    @(negedge clock);
    chk("rv0_once",  bus.rvalid0, 0);

    // preload words for the arbitration tests
    tk(); drv0(1'b1, 1'b1, 1'b0, 9'h001, 32'hA5A50001);
    tk(); drv0(1'b1, 1'b1, 1'b0, 9'h002, 32'h5A5A0002);
    tk(); drv0(1'b0, 1'b0, 1'b0, '0, '0);

    // round robin from reset: 0,1,0,1
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drv0(k < 4, 1'b0, 1'b0, 9'h001, '0);
      drv1(k < 4, 1'b0, 1'b0, 9'h002, '0);
      @(negedge clock);
      chk($sformatf("rr_gnt0_%0d", k), bus.gnt0, (k < 4) && (k % 2 == 0));
      chk($sformatf("rr_gnt1_%0d", k), bus.gnt1, (k < 4) && (k % 2 == 1));
      if (k > 0) begin
        chk($sformatf("rr_rv0_%0d", k), bus.rvalid0, (k % 2 == 1));
        chk($sformatf("rr_rv1_%0d", k), bus.rvalid1, (k % 2 == 0));
        chk($sformatf("rr_rd_%0d", k), bus.rdata, (k % 2 == 1) ? 32'hA5A50001 : 32'h5A5A0002);
      end
      tk();
    end

    // lock burst: 3 locked reads by 0 while 1 waits, release, then 1
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drv0(1'b1, 1'b0, k < 3, 9'h001, '0);
      drv1(1'b1, 1'b0, 1'b0, 9'h002, '0);
      @(negedge clock);
      chk($sformatf("lk_gnt0_%0d", k), bus.gnt0, k < 4);
      chk($sformatf("lk_gnt1_%0d", k), bus.gnt1, k == 4);
      if (k > 0) chk($sformatf("lk_rv0_%0d", k), bus.rvalid0, 1);
      tk();
    end
    drv0(1'b0, 1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, 1'b0, '0, '0);

    // lock held against a waiting requester
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drv0(1'b1, 1'b0, 1'b1, 9'h001, '0);
      drv1(1'b1, 1'b0, 1'b0, 9'h002, '0);
      @(negedge clock);
`ifdef MEM_ARB_LOCK_TIMEOUT_EN
      if (k < 5) begin
        chk($sformatf("to_gnt0_%0d", k), bus.gnt0, k < 4);
        chk($sformatf("to_gnt1_%0d", k), bus.gnt1, k == 4);
      end
`else
      chk($sformatf("ul_gnt0_%0d", k), bus.gnt0, 1);
      chk($sformatf("ul_gnt1_%0d", k), bus.gnt1, 0);
`endif
      tk();
    end
    drv0(1'b0, 1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, 1'b0, '0, '0);

    // async reset right after a read grant drops the pending rvalid
    do_reset();
    tk(); drv0(1'b1, 1'b0, 1'b0, 9'h010, '0);
    @(negedge clock);
    chk("ar_gnt0", bus.gnt0, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_gnt0_low", bus.gnt0, 0);
    chk("ar_men_low",  bus.mem_enable, 0);
    tk();
    chk("ar_rv0_edge", bus.rvalid0, 0);
    drv1(1'b1, 1'b0, 1'b0, 9'h001, '0);
    @(negedge clock);
    chk("ar_rv0_neg",  bus.rvalid0, 0);
    chk("ar_gnt1_low", bus.gnt1, 0);
    tk();
    reset_n = 1'b1;
    @(negedge clock);
    chk("ar_pri_gnt0", bus.gnt0, 1);
    chk("ar_pri_gnt1", bus.gnt1, 0);
    tk();
    @(negedge clock);
    chk("ar_nxt_gnt1", bus.gnt1, 1);
    chk("ar_nxt_rv0",  bus.rvalid0, 1);
    chk("ar_nxt_rd",   bus.rdata, 32'hDEADBEEF);
    tk();
    drv0(1'b0, 1'b0, 1'b0, '0, '0);
    drv1(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clock);
    chk("ar_end_rv1",  bus.rvalid1, 1);
    chk("ar_end_rd",   bus.rdata, 32'hA5A50001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
